rgb_converter_arbiter: RTL and testbench

Round-robin arbiter that shares one RGB_converter instance between two requesters (A, B). It samples a requester's 3-bit colour code on grant and drives the converter's colour/enable inputs. It tracks each in-flight lookup through the converter's fixed read latency and returns the 24-bit rgb result, with a one-cycle valid pulse, to the requester that issued it. It sits between the display/pattern logic and the converter.

---
 rtl/rgb_converter_arbiter.sv | 89 ++++++++
 tb/tb_rgb_converter_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_converter_arbiter.sv
// Round-robin arbiter sharing one RGB converter between requesters A and B.
// Grants are registered one-cycle pulses; each grant launches a tag through a
// LATENCY-deep pipeline so the converter result is routed back to its owner.
module rgb_converter_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [2:0]  colour_a,
  output logic        gnt_a,
  output logic [23:0] rgb_a,
  output logic        valid_a,
  input  logic        req_b,
  input  logic [2:0]  colour_b,
  output logic        gnt_b,
  output logic [23:0] rgb_b,
  output logic        valid_b,
  output logic [2:0]  conv_colour,
  output logic        conv_enable,
  input  logic [23:0] conv_rgb
);

  // ptr = 0: A owns priority on a tie, ptr = 1: B owns it
  logic               ptr;
  logic               elig_a, elig_b, win_a, win_b;
  // tag pipeline: stage 0 is loaded from the grant register, so the last
  // stage lines up with the edge at which conv_rgb already holds the result
  logic [LATENCY-1:0] vld_pipe;
  logic [LATENCY-1:0] id_pipe;   // 1 = B

  // eligibility excludes the requester granted this cycle (no back-to-back)
  always_comb begin
    elig_a = req_a & ~gnt_a;
    elig_b = req_b & ~gnt_b;
    win_a  = elig_a & (~elig_b | ~ptr);
    win_b  = elig_b & ~win_a;
  end

  // grant pulses, converter drive and priority pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      conv_enable <= 1'b0;
      conv_colour <= 3'd0;
      ptr         <= 1'b0;
    end else begin
      gnt_a       <= win_a;
      gnt_b       <= win_b;
      conv_enable <= win_a | win_b;
      if (win_a)      conv_colour <= colour_a;
      else if (win_b) conv_colour <= colour_b;
      if (win_a)      ptr <= 1'b1;
      else if (win_b) ptr <= 1'b0;
    end
  end

  // tag shift register tracking in-flight lookups through the converter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= gnt_a | gnt_b;
      id_pipe[0]  <= gnt_b;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  // return path: capture converter output for the tag leaving the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_a <= 1'b0;
      valid_b <= 1'b0;
      rgb_a   <= 24'd0;
      rgb_b   <= 24'd0;
    end else begin
      valid_a <= vld_pipe[LATENCY-1] & ~id_pipe[LATENCY-1];
      valid_b <= vld_pipe[LATENCY-1] &  id_pipe[LATENCY-1];
      if (vld_pipe[LATENCY-1] & ~id_pipe[LATENCY-1]) rgb_a <= conv_rgb;
      if (vld_pipe[LATENCY-1] &  id_pipe[LATENCY-1]) rgb_b <= conv_rgb;
    end
  end

endmodule

// File: tb/tb_rgb_converter_arbiter.sv
// Bench for rgb_converter_arbiter: two instances (LATENCY 1 and 3) share the
// same requester stimulus, each with its own converter model; a queue-based
// reference model predicts grants and returned results every cycle.
module tb_rgb_converter_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [2:0]  colour_a = '0, colour_b = '0;

  logic        gnt_a1, gnt_b1, valid_a1, valid_b1, conv_en1;
  logic [23:0] rgb_a1, rgb_b1, conv_rgb1;
  logic [2:0]  conv_col1;
  logic        gnt_a3, gnt_b3, valid_a3, valid_b3, conv_en3;
  logic [23:0] rgb_a3, rgb_b3, conv_rgb3;
  logic [2:0]  conv_col3;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  rgb_converter_arbiter #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .colour_a(colour_a), .gnt_a(gnt_a1), .rgb_a(rgb_a1), .valid_a(valid_a1),
    .req_b(req_b), .colour_b(colour_b), .gnt_b(gnt_b1), .rgb_b(rgb_b1), .valid_b(valid_b1),
    .conv_colour(conv_col1), .conv_enable(conv_en1), .conv_rgb(conv_rgb1));

  rgb_converter_arbiter #(.LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .colour_a(colour_a), .gnt_a(gnt_a3), .rgb_a(rgb_a3), .valid_a(valid_a3),
    .req_b(req_b), .colour_b(colour_b), .gnt_b(gnt_b3), .rgb_b(rgb_b3), .valid_b(valid_b3),
    .conv_colour(conv_col3), .conv_enable(conv_en3), .conv_rgb(conv_rgb3));

  // colour code bits select full-intensity R, G, B channels
  function automatic logic [23:0] cmap(input logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  // converter models: result for an enable-high cycle appears LATENCY edges later
  always @(posedge clk or negedge rst_n)
    if (!rst_n) conv_rgb1 <= '0;
    else if (conv_en1) conv_rgb1 <= cmap(conv_col1);

  logic       e3a, e3b;
  logic [2:0] c3a, c3b;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      conv_rgb3 <= '0; e3a <= 0; e3b <= 0; c3a <= 0; c3b <= 0;
    end else begin
      if (e3b) conv_rgb3 <= cmap(c3b);
      e3a <= conv_en3; c3a <= conv_col3;
      e3b <= e3a;      c3b <= c3a;
    end

  // reference model
  typedef struct { int due; logic id; logic [23:0] rgb; } ret_t;
  ret_t        q1[$], q3[$];
  int          cyc;
  logic        m_ga, m_gb, m_en, m_ptr;
  logic [2:0]  m_col;
  logic        m_va1, m_vb1, m_va3, m_vb3;
  logic [23:0] m_ra1, m_rb1, m_ra3, m_rb3;

  task automatic pop_ret(inout ret_t q[$], output logic va, output logic vb,
                         inout logic [23:0] ra, inout logic [23:0] rb);
    va = 0; vb = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      if (q[0].id) begin vb = 1; rb = q[0].rgb; end
      else         begin va = 1; ra = q[0].rgb; end
      void'(q.pop_front());
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic ea, eb, wa, wb;
    if (!rst_n) begin
      q1.delete(); q3.delete(); cyc = 0;
      m_ga = 0; m_gb = 0; m_en = 0; m_ptr = 0; m_col = 0;
      m_va1 = 0; m_vb1 = 0; m_va3 = 0; m_vb3 = 0;
      m_ra1 = 0; m_rb1 = 0; m_ra3 = 0; m_rb3 = 0;
    end else begin
      cyc++;
      ea = req_a && !m_ga;
      eb = req_b && !m_gb;
      wa = ea && (!eb || !m_ptr);
      wb = eb && !wa;
      m_ga = wa; m_gb = wb; m_en = wa || wb;
      if (wa) begin m_col = colour_a; m_ptr = 1; end
      else if (wb) begin m_col = colour_b; m_ptr = 0; end
      if (m_en) begin
        q1.push_back('{cyc + 2, wb, cmap(m_col)});
        q3.push_back('{cyc + 4, wb, cmap(m_col)});
      end
      pop_ret(q1, m_va1, m_vb1, m_ra1, m_rb1);
      pop_ret(q3, m_va3, m_vb3, m_ra3, m_rb3);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    chk("gnt_a1", gnt_a1, m_ga);     chk("gnt_b1", gnt_b1, m_gb);
    chk("en1", conv_en1, m_en);      chk("col1", conv_col1, m_col);
    chk("valid_a1", valid_a1, m_va1); chk("valid_b1", valid_b1, m_vb1);
    chk("rgb_a1", rgb_a1, m_ra1);    chk("rgb_b1", rgb_b1, m_rb1);
    chk("gnt_a3", gnt_a3, m_ga);     chk("gnt_b3", gnt_b3, m_gb);
    chk("en3", conv_en3, m_en);      chk("col3", conv_col3, m_col);
    chk("valid_a3", valid_a3, m_va3); chk("valid_b3", valid_b3, m_vb3);
    chk("rgb_a3", rgb_a3, m_ra3);    chk("rgb_b3", rgb_b3, m_rb3);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // reset with both requesting
    req_a = 1; req_b = 1; colour_a = 3'd5; colour_b = 3'd3;
    tick(3);
    chk("rst_gnt", {gnt_a1, gnt_b1, gnt_a3, gnt_b3}, 4'b0);
    rst_n = 1;
    tick(1);
    chk("first_gnt_a", {gnt_a1, gnt_b1}, 2'b10);
    req_a = 0; req_b = 0;
    tick(6);

    // single A request, colour 4
    req_a = 1; colour_a = 3'd4;
    tick(1);
    chk("single_gnt", gnt_a1, 1'b1);
    chk("single_col", conv_col1, 3'd4);
    req_a = 0;
    tick(2);
    chk("single_valid1", valid_a1, 1'b1);
    chk("single_rgb1", rgb_a1, 24'hFF0000);
    tick(2);
    chk("single_valid3", valid_a3, 1'b1);
    chk("single_rgb3", rgb_a3, 24'hFF0000);
    tick(2);

    // contention: both held high for 8 cycles
    req_a = 1; req_b = 1; colour_a = 3'd1; colour_b = 3'd2;
    tick(8);
    req_a = 0; req_b = 0;
    tick(6);
    chk("cont_rgb_a", rgb_a1, 24'h0000FF);
    chk("cont_rgb_b", rgb_b1, 24'h00FF00);

    // pointer fairness: A alone, then tie -> B, then tie -> A
    req_a = 1; colour_a = 3'd2;
    tick(1); req_a = 0;
    tick(1);
    req_a = 1; req_b = 1;
    tick(1);
    chk("fair_b", {gnt_a1, gnt_b1}, 2'b01);
    req_a = 0; req_b = 0;
    tick(2);
    req_a = 1; req_b = 1;
    tick(1);
    chk("fair_a", {gnt_a1, gnt_b1}, 2'b10);
    req_a = 0; req_b = 0;
    tick(6);

    // reset while a B lookup is in flight
    req_b = 1; colour_b = 3'd7;
    tick(1); req_b = 0;
    #2 rst_n = 0;
    tick(2);
    #2 rst_n = 1;
    tick(5);
    chk("midrst_rgb_b", rgb_b3, 24'd0);
    req_b = 1; colour_b = 3'd6;
    tick(1); req_b = 0;
    tick(2);
    chk("post_rgb_b1", rgb_b1, 24'hFFFF00);
    tick(2);
    chk("post_rgb_b3", rgb_b3, 24'hFFFF00);

    // back-to-back A,B,A on the LATENCY=3 instance
    req_a = 1; req_b = 1; colour_a = 3'd3; colour_b = 3'd5;
    tick(1);
    chk("b2b_gnt0", {gnt_a3, gnt_b3}, 2'b10);
    colour_a = 3'd6;
    tick(1);
    chk("b2b_gnt1", {gnt_a3, gnt_b3}, 2'b01);
    req_b = 0;
    tick(1);
    req_a = 0;
    tick(2);
    chk("b2b_v0", {valid_a3, rgb_a3}, {1'b1, 24'h00FFFF});
    tick(1);
    chk("b2b_v1", {valid_b3, rgb_b3}, {1'b1, 24'hFF00FF});
    tick(1);
    chk("b2b_v2", {valid_a3, rgb_a3}, {1'b1, 24'hFFFF00});
    tick(4);

    // randomized traffic: each requester holds its request until granted
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!req_a || gnt_a1) begin req_a = 1'($urandom); colour_a = 3'($urandom); end
      if (!req_b || gnt_b1) begin req_b = 1'($urandom); colour_b = 3'($urandom); end
      if (i == 200) begin #2 rst_n = 0; end
      if (i == 202) begin #2 rst_n = 1; end
    end
    req_a = 0; req_b = 0;
    tick(8);
    chk("drain_q1", q1.size(), 0);
    chk("drain_q3", q3.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
